// File: rtl/led_pkg.sv
// Shared definitions for the LED shift-chain arbiter: frame geometry,
// default clock divider, requester count and the FSM state encoding.
package led_pkg;

  localparam int LED_WIDTH   = 16;
  localparam int LED_CLK_DIV = 4;
  localparam int N_LED_REQ   = 2;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } led_state_e;

endpackage

// File: rtl/led_rr_arb2.sv
// Two-input round-robin pick: on contention the requester that was not
// served last wins; a lone requester always wins. Purely combinational.
module led_rr_arb2
  import led_pkg::*;
(
  input  logic [N_LED_REQ-1:0] req,
  input  logic                 ptr,
  output logic [N_LED_REQ-1:0] gnt
);

  // ptr holds the index of the requester served most recently.
  assign gnt[0] = req[0] & (~req[1] | ptr);
  assign gnt[1] = req[1] & (~req[0] | ~ptr);

endmodule

// File: rtl/led_shift_arbiter.sv
// Owns the serial LED chain: arbitrates two pattern sources round-robin and
// shifts the granted frame out MSB-first on a divided led_clk.
module led_shift_arbiter
  import led_pkg::*;
#(
  parameter int WIDTH   = LED_WIDTH,
  parameter int CLK_DIV = LED_CLK_DIV,
  parameter bit INVERT  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_LED_REQ-1:0] req,
  input  logic [WIDTH-1:0]     data0,
  input  logic [WIDTH-1:0]     data1,
  output logic [N_LED_REQ-1:0] gnt,
  output logic                 done,
  output logic                 busy,
  output logic                 led_do,
  output logic                 led_clk,
  output logic                 led_clr,
  output logic                 led_pen
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  led_state_e            state_q, state_d;
  logic [WIDTH-1:0]      sreg_q, sreg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  ptr_q, ptr_d;
  logic [N_LED_REQ-1:0]  gnt_q, gnt_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  led_do_q, led_do_d;
  logic                  led_clk_q, led_clk_d;
  logic                  led_pen_q, led_pen_d;
  logic                  led_clr_q;

  logic [N_LED_REQ-1:0]  pick;
  logic [WIDTH-1:0]      cap;
  logic                  div_last;

  led_rr_arb2 u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (pick)
  );

  assign cap      = pick[1] ? data1 : data0;
  assign div_last = (div_q == DIV_W'(CLK_DIV - 1));

  always_comb begin
    // NOTE: every target gets a default first so no path leaves one unassigned
    // (which would infer a latch).
    state_d   = state_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    led_do_d  = led_do_q;
    led_clk_d = led_clk_q;
    led_pen_d = led_pen_q;

    unique case (state_q)
      IDLE: begin
        // Hold off until the chain clear has been released.
        if (led_clr_q && (|req)) begin
          gnt_d     = pick;
          busy_d    = 1'b1;
          sreg_d    = cap;
          cnt_d     = CNT_W'(WIDTH - 1);
          div_d     = '0;
          led_pen_d = 1'b0;
          led_clk_d = 1'b0;
          led_do_d  = cap[WIDTH-1] ^ INVERT;
          state_d   = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (div_last) begin
          div_d     = '0;
          led_clk_d = 1'b1;
          state_d   = SHIFT_HI;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      SHIFT_HI: begin
        if (div_last) begin
          div_d     = '0;
          led_clk_d = 1'b0;
          if (cnt_q == '0) begin
            led_pen_d = 1'b1;
            done_d    = 1'b1;
            state_d   = LATCH;
          end else begin
            // led_do only moves on the falling edge of led_clk.
            sreg_d   = sreg_q << 1;
            cnt_d    = cnt_q - CNT_W'(1);
            led_do_d = sreg_q[WIDTH-2] ^ INVERT;
            state_d  = SHIFT_LO;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      LATCH: begin
        gnt_d    = '0;
        busy_d   = 1'b0;
        ptr_d    = gnt_q[1];
        led_do_d = INVERT;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      cnt_q     <= '0;
      div_q     <= '0;
      ptr_q     <= 1'b1;
      gnt_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      led_do_q  <= INVERT;
      led_clk_q <= 1'b0;
      led_pen_q <= 1'b1;
      led_clr_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      led_do_q  <= led_do_d;
      led_clk_q <= led_clk_d;
      led_pen_q <= led_pen_d;
      led_clr_q <= 1'b1;
    end
  end

  assign gnt     = gnt_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign led_do  = led_do_q;
  assign led_clk = led_clk_q;
  assign led_clr = led_clr_q;
  assign led_pen = led_pen_q;

endmodule

// File: tb/tb_led_shift_arbiter.sv
// Scoreboard bench: the driver queues expected serial bits and frame records,
// a monitor pops and compares them as led_clk rises and done pulses appear.
module tb_led_shift_arbiter;
  import led_pkg::*;

  typedef struct {
    logic [1:0] gnt;
    int         len;
  } frame_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [15:0] data0, data1;
  logic [1:0]  gnt;
  logic        done, busy, led_do, led_clk, led_clr, led_pen;

  logic [1:0]  req_b;
  logic [15:0] data0_b, data1_b;
  logic [1:0]  gnt_b;
  logic        done_b, busy_b, led_do_b, led_clk_b, led_clr_b, led_pen_b;

  logic   exp_bits[$];
  frame_t exp_frames[$];
  int     n_checks = 0;
  int     n_pass   = 0;

  always #5 clk = ~clk;

  led_shift_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .data0(data0), .data1(data1),
    .gnt(gnt), .done(done), .busy(busy), .led_do(led_do),
    .led_clk(led_clk), .led_clr(led_clr), .led_pen(led_pen)
  );

  led_shift_arbiter #(.WIDTH(16), .CLK_DIV(1), .INVERT(1'b0)) dut_div1 (
    .clk(clk), .reset(reset), .req(req_b), .data0(data0_b), .data1(data1_b),
    .gnt(gnt_b), .done(done_b), .busy(busy_b), .led_do(led_do_b),
    .led_clk(led_clk_b), .led_clr(led_clr_b), .led_pen(led_pen_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Expected serial stream for the default build (INVERT=1): ~pattern, MSB first.
  task automatic push_frame(input logic [15:0] pattern, input logic [1:0] g);
    logic [15:0] inv;
    frame_t f;
    inv = ~pattern;
    for (int i = 15; i >= 0; i--) exp_bits.push_back(inv[i]);
    f.gnt = g;
    f.len = 129;
    exp_frames.push_back(f);
  endtask

  task automatic wait_busy(input string name);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!busy && t < 300);
    check(name, busy, 1'b1);
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done && t < 400);
    check(name, done, 1'b1);
  endtask

  task automatic wait_rises(input int n);
    int   seen = 0;
    int   t = 0;
    logic prev;
    prev = led_clk;
    while (seen < n && t < 300) begin
      @(negedge clk);
      t++;
      if (led_clk && !prev) seen++;
      prev = led_clk;
    end
    check("rise_wait", seen, n);
  endtask

  // Monitor: compares each bit at a led_clk rise and each frame at done.
  initial begin : monitor
    logic   prev_clk;
    int     busy_cnt;
    logic   b;
    frame_t f;
    prev_clk = 1'b0;
    busy_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_clk = 1'b0;
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        if (led_clk && !prev_clk) begin
          check("pen_low_in_shift", led_pen, 1'b0);
          check("bit_expected", exp_bits.size() > 0, 1'b1);
          if (exp_bits.size() > 0) begin
            b = exp_bits.pop_front();
            check("led_do_bit", led_do, b);
          end
        end
        if (done) begin
          check("frame_expected", exp_frames.size() > 0, 1'b1);
          if (exp_frames.size() > 0) begin
            f = exp_frames.pop_front();
            check("frame_gnt", gnt, f.gnt);
            check("frame_len", busy_cnt, f.len);
            check("pen_at_latch", led_pen, 1'b1);
          end
        end
        if (!busy) busy_cnt = 0;
        prev_clk = led_clk;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int gap;
    reset   = 1'b0;
    req     = 2'b01;
    data0   = 16'hA5C3;
    data1   = 16'h0000;
    req_b   = 2'b00;
    data0_b = 16'h0000;
    data1_b = 16'hFFFF;

    // Reset state with a request already pending.
    repeat (3) @(negedge clk);
    check("rst_led_clr", led_clr, 1'b0);
    check("rst_led_pen", led_pen, 1'b1);
    check("rst_gnt", gnt, 2'b00);
    check("rst_led_clk", led_clk, 1'b0);
    check("rst_led_do", led_do, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);

    push_frame(16'hA5C3, 2'b01);
    reset = 1'b1;
    @(negedge clk);
    check("clr_released", led_clr, 1'b1);
    check("no_grant_yet", gnt, 2'b00);
    @(negedge clk);
    check("first_grant", gnt, 2'b01);
    check("first_busy", busy, 1'b1);
    check("first_pen", led_pen, 1'b0);
    req = 2'b00;
    wait_done("done_frame_a5c3");

    // Requester 1 alone, leaves the pointer at 1.
    data1 = 16'h5A3C;
    req   = 2'b10;
    push_frame(16'h5A3C, 2'b10);
    wait_busy("busy_req1");
    req = 2'b00;
    wait_done("done_req1");

    // Contention for four frames: 01,10,01,10 with a one-cycle busy gap.
    data0 = 16'h1234;
    data1 = 16'h00FF;
    req   = 2'b11;
    push_frame(16'h1234, 2'b01);
    push_frame(16'h00FF, 2'b10);
    push_frame(16'h1234, 2'b01);
    push_frame(16'h00FF, 2'b10);
    wait_busy("busy_contend");
    for (int i = 0; i < 3; i++) begin
      wait_done("done_contend");
      gap = 0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (busy) break;
        gap++;
      end
      check("busy_gap", gap, 1);
    end
    req = 2'b00;
    wait_done("done_contend_last");

    // Drop req0 and clobber data0 at bit 5; the frame must be unaffected.
    data0 = 16'h3C5A;
    req   = 2'b01;
    push_frame(16'h3C5A, 2'b01);
    wait_busy("busy_disturb");
    wait_rises(5);
    req   = 2'b00;
    data0 = 16'h0000;
    wait_done("done_disturb");

    // Reset at bit 8 abandons the frame; a fresh one starts from the MSB.
    data0 = 16'hF00F;
    req   = 2'b01;
    push_frame(16'hF00F, 2'b01);
    wait_busy("busy_prereset");
    wait_rises(8);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_led_clk", led_clk, 1'b0);
    check("midrst_led_pen", led_pen, 1'b1);
    check("midrst_gnt", gnt, 2'b00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_led_clr", led_clr, 1'b0);
    exp_bits.delete();
    exp_frames.delete();
    repeat (2) begin
      @(negedge clk);
      check("midrst_no_done", done, 1'b0);
    end
    push_frame(16'hF00F, 2'b01);
    reset = 1'b1;
    wait_busy("busy_postreset");
    req = 2'b00;
    wait_done("done_postreset");

    // CLK_DIV=1, INVERT=0 build: toggling led_clk, all-ones data, 33 cycles.
    begin : div1_test
      int   k;
      int   t;
      int   rises;
      int   done_at;
      logic prev;
      req_b = 2'b10;
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!busy_b && t < 10);
      check("div1_grant", gnt_b, 2'b10);
      req_b   = 2'b00;
      k       = 1;
      rises   = 0;
      done_at = 0;
      prev    = 1'b0;
      while (busy_b && k < 40) begin
        check("div1_led_clk", led_clk_b, (k % 2) == 0);
        if (led_clk_b && !prev) begin
          rises++;
          check("div1_led_do", led_do_b, 1'b1);
        end
        if (done_b) done_at = k;
        prev = led_clk_b;
        @(negedge clk);
        k++;
      end
      check("div1_len", k - 1, 33);
      check("div1_done_at", done_at, 33);
      check("div1_rises", rises, 16);
    end

    repeat (3) @(negedge clk);
    check("bits_drained", exp_bits.size(), 0);
    check("frames_drained", exp_frames.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
